// File: rtl/score_keeper.sv
// Pong game-state sequencer and frame-synchronous score publisher.
// Optional attract-mode auto-restart from game-over: define SCORE_KEEPER_AUTORESTART_EN.
module score_keeper #(
  parameter logic [2:0] MAX_SCORE      = 3'd7,
  parameter logic [7:0] SERVE_FRAMES   = 8'd60,
  parameter logic [7:0] RESTART_FRAMES = 8'd180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       new_game,
  input  logic       goal_valid,
  input  logic       goal_player,
  output logic       goal_ready,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       serve,
  output logic       serve_dir,
  output logic       running,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, HOLD, PLAY, OVER} state_t;

  state_t     state;
  logic [7:0] fc;
  logic [2:0] wl, wr;
  logic       accept, restart;
  logic [2:0] cur, inc;

  always_comb begin
    accept  = goal_valid && goal_ready;
    cur     = goal_player ? wr : wl;
    inc     = (cur >= MAX_SCORE) ? MAX_SCORE : cur + 3'd1;
`ifdef SCORE_KEEPER_AUTORESTART_EN
    restart = new_game || (state == OVER && frame_tick && fc == 8'd1);
`else
    restart = new_game;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fc         <= 8'd0;
      wl         <= 3'd0;
      wr         <= 3'd0;
      score_l    <= 3'd0;
      score_r    <= 3'd0;
      goal_ready <= 1'b0;
      serve      <= 1'b0;
      serve_dir  <= 1'b0;
      running    <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      serve <= 1'b0;
      // Published copies sample the pre-update working scores, so a goal on a tick shows next tick.
      if (frame_tick) begin
        score_l <= wl;
        score_r <= wr;
      end
      if (restart) begin
        wl         <= 3'd0;
        wr         <= 3'd0;
        serve_dir  <= 1'b0;
        fc         <= SERVE_FRAMES;
        state      <= HOLD;
        goal_ready <= 1'b0;
        running    <= 1'b0;
        game_over  <= 1'b0;
        winner     <= 1'b0;
      end else begin
        case (state)
          HOLD: if (frame_tick) begin
            if (fc == 8'd1) begin
              serve      <= 1'b1;
              state      <= PLAY;
              goal_ready <= 1'b1;
              running    <= 1'b1;
            end else begin
              fc <= fc - 8'd1;
            end
          end
          PLAY: if (accept) begin
            if (goal_player) wr <= inc;
            else             wl <= inc;
            serve_dir  <= goal_player;
            goal_ready <= 1'b0;
            running    <= 1'b0;
            if (inc == MAX_SCORE) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= ~goal_player;
              // Only counted down in the auto-restart build; harmless otherwise.
              fc        <= RESTART_FRAMES;
            end else begin
              state <= HOLD;
              fc    <= SERVE_FRAMES;
            end
          end
`ifdef SCORE_KEEPER_AUTORESTART_EN
          OVER: if (frame_tick) fc <= fc - 8'd1;
`else
          OVER: begin end
`endif
          default: begin end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; published scores checked against a tick-ordered scoreboard.
module tb_score_keeper;
  localparam int SF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, new_game = 1'b0, goal_valid = 1'b0, goal_player = 1'b0;
  logic       goal_ready, serve, serve_dir, running, game_over, winner;
  logic [2:0] score_l, score_r;

  score_keeper #(.MAX_SCORE(3'd7), .SERVE_FRAMES(8'd3), .RESTART_FRAMES(8'd2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .new_game(new_game),
    .goal_valid(goal_valid), .goal_player(goal_player), .goal_ready(goal_ready),
    .score_l(score_l), .score_r(score_r), .serve(serve), .serve_dir(serve_dir),
    .running(running), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [2:0] ml = 3'd0, mr = 3'd0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on negedge, sample 1ns after posedge; each tick publishes the model's scores.
  task automatic step(input logic r, input logic ft, input logic ng, input logic gv, input logic gp);
    logic [5:0] e;
    @(negedge clk);
    rst = r; frame_tick = ft; new_game = ng; goal_valid = gv; goal_player = gp;
    if (ft) exp_q.push_back({ml, mr});
    @(posedge clk);
    #1;
    if (ft) begin
      e = exp_q.pop_front();
      chk("score_l", {5'd0, score_l}, {5'd0, e[5:3]});
      chk("score_r", {5'd0, score_r}, {5'd0, e[2:0]});
    end
  endtask

  task automatic tick(); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic serve_seq();
    for (int i = 1; i <= SF; i++) begin
      tick();
      chk("serve_at_tick", {7'd0, serve}, (i == SF) ? 8'd1 : 8'd0);
      idle();
    end
    chk("running_after_serve", {7'd0, running}, 8'd1);
    chk("ready_after_serve", {7'd0, goal_ready}, 8'd1);
    chk("serve_one_cycle", {7'd0, serve}, 8'd0);
  endtask

  task automatic goal(input logic p, input logic ft);
    step(1'b0, ft, 1'b0, 1'b1, p);
    if (p) mr = mr + 3'd1;
    else   ml = ml + 3'd1;
    chk("ready_drops", {7'd0, goal_ready}, 8'd0);
    chk("serve_dir", {7'd0, serve_dir}, {7'd0, p});
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_score_l", {5'd0, score_l}, 8'd0);
    chk("rst_score_r", {5'd0, score_r}, 8'd0);
    chk("rst_ready", {7'd0, goal_ready}, 8'd0);
    chk("rst_serve", {7'd0, serve}, 8'd0);
    chk("rst_serve_dir", {7'd0, serve_dir}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_game_over", {7'd0, game_over}, 8'd0);
    chk("rst_winner", {7'd0, winner}, 8'd0);

    // IDLE ignores goals for 5 frames
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("idle_ready", {7'd0, goal_ready}, 8'd0);
      chk("idle_running", {7'd0, running}, 8'd0);
      idle();
    end

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ng_running", {7'd0, running}, 8'd0);
    serve_seq();

    // goal with coincident tick publishes pre-goal value
    goal(1'b1, 1'b1);
    chk("goal_running", {7'd0, running}, 8'd0);
    for (int g = 2; g <= 7; g++) begin
      serve_seq();
      goal(1'b1, 1'b0);
    end
    chk("over_game_over", {7'd0, game_over}, 8'd1);
    chk("over_winner", {7'd0, winner}, 8'd0);
    chk("over_running", {7'd0, running}, 8'd0);
    tick();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_ready", {7'd0, goal_ready}, 8'd0);
    chk("over_persist", {7'd0, game_over}, 8'd1);

`ifdef SCORE_KEEPER_AUTORESTART_EN
    tick();
    ml = 3'd0; mr = 3'd0;
    chk("auto_game_over", {7'd0, game_over}, 8'd0);
    chk("auto_running", {7'd0, running}, 8'd0);
    serve_seq();
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      idle();
    end
    chk("over_300_game_over", {7'd0, game_over}, 8'd1);
    chk("over_300_winner", {7'd0, winner}, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ml = 3'd0; mr = 3'd0;
    chk("ng_from_over", {7'd0, game_over}, 8'd0);
    serve_seq();
`endif

    goal(1'b1, 1'b0);
    serve_seq();
    // new_game beats a simultaneous goal
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    ml = 3'd0; mr = 3'd0;
    chk("ng_goal_dir", {7'd0, serve_dir}, 8'd0);
    chk("ng_goal_running", {7'd0, running}, 8'd0);
    chk("ng_goal_ready", {7'd0, goal_ready}, 8'd0);
    chk("ng_goal_over", {7'd0, game_over}, 8'd0);
    serve_seq();

    // reset on the would-be serve tick suppresses the pulse
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_hold_serve", {7'd0, serve}, 8'd0);
    chk("rst_hold_running", {7'd0, running}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_serve", {7'd0, serve}, 8'd0);
      chk("post_rst_running", {7'd0, running}, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
